// File: rtl/cp0_reg_pkg.sv
// cp0_reg_pkg: CP0 register numbers and reset/write-mask constants
// shared by the CP0 register file and its timer.
package cp0_reg_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    // CU0 set out of reset
    localparam logic [31:0] CP0_STATUS_RST = 32'h1000_0000;

    // IV[23], WP[22], IP[9:8] are the only software-writable Cause bits
    localparam logic [31:0] CP0_CAUSE_WMASK = 32'h00C0_0300;

    function automatic logic [31:0] cause_merge(
        input logic [31:0] cur,
        input logic [31:0] wdata
    );
        return (cur & ~CP0_CAUSE_WMASK) | (wdata & CP0_CAUSE_WMASK);
    endfunction

endpackage

// File: rtl/cp0_reg_timer.sv
// cp0_timer: free-running Count, Compare and the sticky Compare-match
// interrupt. Match logic exists only when CP0_TIMER_INT_EN is defined.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    // Count increments every cycle; a software load beats the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            count_o <= '0;
        end else if (count_we) begin
            count_o <= wdata;
        end else begin
            count_o <= count_o + 32'd1;
        end
    end

    // Compare is a plain software-loaded register
    always_ff @(posedge clk) begin
        if (rst) begin
            compare_o <= '0;
        end else if (compare_we) begin
            compare_o <= wdata;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic match;

    // Compare == 0 is treated as "timer disarmed"
    assign match = (compare_o != '0) && (count_o == compare_o);

    // Sticky interrupt; a Compare write acknowledges it and beats a match
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_int_o <= 1'b0;
        end else if (compare_we) begin
            timer_int_o <= 1'b0;
        end else if (match) begin
            timer_int_o <= 1'b1;
        end
    end
`else
    assign timer_int_o = 1'b0;
`endif

endmodule

// File: rtl/cp0_reg.sv
// cp0_reg: CP0 register file (Status, Cause, EPC, PRId, Config, read mux)
// around cp0_timer. Optional timer interrupt: CP0_TIMER_INT_EN.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0048_0102,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [31:0] cause_w;
    logic [31:0] epc_q;

    assign wr_count   = we_i && (waddr_i == CP0_REG_COUNT);
    assign wr_compare = we_i && (waddr_i == CP0_REG_COMPARE);
    assign wr_status  = we_i && (waddr_i == CP0_REG_STATUS);
    assign wr_cause   = we_i && (waddr_i == CP0_REG_CAUSE);
    assign wr_epc     = we_i && (waddr_i == CP0_REG_EPC);

    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_we    (wr_count),
        .compare_we  (wr_compare),
        .wdata       (data_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .timer_int_o (timer_int_o)
    );

    // Status: fully writable
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= CP0_STATUS_RST;
        end else if (wr_status) begin
            status_q <= data_i;
        end
    end

    // EPC: fully writable
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q <= '0;
        end else if (wr_epc) begin
            epc_q <= data_i;
        end
    end

    assign cause_w = wr_cause ? cause_merge(cause_q, data_i) : cause_q;

    // Cause: IP[15:10] tracks int_i every cycle, masked bits from software
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= '0;
        end else begin
            cause_q <= {cause_w[31:16], int_i, cause_w[9:0]};
        end
    end

    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;
    assign config_o = CONFIG_VAL;
    assign prid_o   = PRID_VAL;

    // Read mux: current register values, no write bypass, 0 during reset
    always_comb begin
        data_o = '0;
        if (!rst) begin
            unique case (raddr_i)
                CP0_REG_COUNT:   data_o = count_o;
                CP0_REG_COMPARE: data_o = compare_o;
                CP0_REG_STATUS:  data_o = status_q;
                CP0_REG_CAUSE:   data_o = cause_q;
                CP0_REG_EPC:     data_o = epc_q;
                CP0_REG_PRID:    data_o = PRID_VAL;
                CP0_REG_CONFIG:  data_o = CONFIG_VAL;
                default:         data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed plus randomized checks of cp0_reg against a
// field-level reference model; honours CP0_TIMER_INT_EN.
module tb_cp0_reg;

`ifdef CP0_TIMER_INT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    localparam logic [31:0] PRID = 32'h0048_0102;
    localparam logic [31:0] CFG  = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] data_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [5:0]  int_i = '0;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic        timer_int_o;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model, kept as architectural fields
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic [31:0] m_status;
    logic [31:0] m_epc;
    logic        m_iv;
    logic        m_wp;
    logic [5:0]  m_ip;
    logic [1:0]  m_sw;
    logic        m_tint;

    cp0_reg dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .data_i      (data_i),
        .raddr_i     (raddr_i),
        .int_i       (int_i),
        .data_o      (data_o),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .config_o    (config_o),
        .prid_o      (prid_o),
        .timer_int_o (timer_int_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_cause();
        return {8'h00, m_iv, m_wp, 6'h00, m_ip, m_sw, 8'h00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (rst) return 32'h0;
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            5'd16:   return CFG;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_update();
        bit hit;
        if (rst) begin
            m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
            m_epc = 0; m_iv = 0; m_wp = 0; m_ip = 0; m_sw = 0;
            m_tint = 0;
        end else begin
            hit = TEN && (m_compare != 0) && (m_count == m_compare);
            if (we_i && waddr_i == 5'd9) m_count = data_i;
            else m_count = m_count + 32'd1;
            if (we_i && waddr_i == 5'd11) begin
                m_compare = data_i;
                m_tint = 1'b0;
            end else if (hit) begin
                m_tint = 1'b1;
            end
            if (we_i && waddr_i == 5'd12) m_status = data_i;
            if (we_i && waddr_i == 5'd14) m_epc = data_i;
            if (we_i && waddr_i == 5'd13) begin
                m_iv = data_i[23];
                m_wp = data_i[22];
                m_sw = data_i[9:8];
            end
            m_ip = int_i;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("count", count_o, m_count);
        chk("compare", compare_o, m_compare);
        chk("status", status_o, m_status);
        chk("cause", cause_o, m_cause());
        chk("epc", epc_o, m_epc);
        chk("config", config_o, CFG);
        chk("prid", prid_o, PRID);
        chk("timer_int", 32'(timer_int_o), 32'(m_tint));
        chk("data_o", data_o, m_read(raddr_i));
    endtask

    task automatic step(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra,
                        input logic [5:0] irq);
        rst = r; we_i = w; waddr_i = wa; data_i = wd;
        raddr_i = ra; int_i = irq;
        @(posedge clk);
        model_update();
        #1;
        chk_all();
    endtask

    task automatic idle(input logic [4:0] ra);
        step(1'b0, 1'b0, 5'd0, 32'h0, ra, 6'd0);
    endtask

    initial begin
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  list [7];
        list = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

        // reset, with a write that must be discarded
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd15, 6'd0);
        step(1'b1, 1'b1, 5'd14, 32'hDEAD_BEEF, 5'd15, 6'd0);
        chk("rst_data_o", data_o, 32'h0);
        chk("rst_status", status_o, 32'h1000_0000);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_tint", 32'(timer_int_o), 32'h0);

        repeat (5) idle(5'd15);
        chk("idle5_count", count_o, 32'd5);
        chk("idle5_prid_rd", data_o, PRID);

        // Compare written at count 3, match at 20
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 6'd0);
        repeat (3) idle(5'd9);
        chk("cnt3", count_o, 32'd3);
        step(1'b0, 1'b1, 5'd11, 32'd20, 5'd11, 6'd0);
        for (int i = 0; i < 40 && count_o != 32'd20; i++) idle(5'd9);
        chk("reach20", count_o, 32'd20);
        chk("tint_pre", 32'(timer_int_o), 32'h0);
        idle(5'd9);
        chk("tint_rise", 32'(timer_int_o), 32'(TEN));
        repeat (3) idle(5'd9);
        chk("tint_hold", 32'(timer_int_o), 32'(TEN));
        step(1'b0, 1'b1, 5'd11, 32'd100, 5'd11, 6'd0);
        chk("tint_clr", 32'(timer_int_o), 32'h0);

        // Count wrap
        step(1'b0, 1'b1, 5'd9, 32'hFFFF_FFFE, 5'd9, 6'd0);
        chk("wrap0", data_o, 32'hFFFF_FFFE);
        idle(5'd9);
        chk("wrap1", count_o, 32'hFFFF_FFFF);
        idle(5'd9);
        chk("wrap2", count_o, 32'h0);

        // Cause write mask and IP sampling
        step(1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'b101010);
        chk("cause_wr", cause_o, 32'h00C0_AB00);
        idle(5'd13);
        chk("cause_iplag", cause_o, 32'h00C0_0300);

        // Compare write coinciding with a match
        step(1'b0, 1'b1, 5'd11, 32'd60, 5'd11, 6'd0);
        step(1'b0, 1'b1, 5'd9, 32'd57, 5'd9, 6'd0);
        repeat (3) idle(5'd9);
        chk("cnt60", count_o, 32'd60);
        step(1'b0, 1'b1, 5'd11, 32'd200, 5'd11, 6'd0);
        chk("same_cyc_tint", 32'(timer_int_o), 32'h0);
        idle(5'd11);
        chk("same_cyc_tint2", 32'(timer_int_o), 32'h0);

        // read-only registers
        step(1'b0, 1'b1, 5'd15, 32'hFFFF_FFFF, 5'd15, 6'd0);
        chk("prid_ro", data_o, PRID);
        step(1'b0, 1'b1, 5'd16, 32'h0, 5'd16, 6'd0);
        chk("config_ro", data_o, CFG);

        // reset beats an EPC write
        step(1'b0, 1'b1, 5'd14, 32'h0000_1234, 5'd14, 6'd0);
        chk("epc_wr", epc_o, 32'h0000_1234);
        step(1'b1, 1'b1, 5'd14, 32'hBFC0_0100, 5'd14, 6'd0);
        chk("epc_rst", epc_o, 32'h0);
        idle(5'd14);

        // randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 9) < 7) wa = list[$urandom_range(0, 6)];
            else wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            if (wa == 5'd11 && $urandom_range(0, 1) == 1)
                wd = m_count + 32'($urandom_range(1, 6));
            step(1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), wa, wd,
                 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
